// File: rtl/delay_line_mc_pkg.sv
// Shared widths and defaults for the multi-channel ADPCM sample delay line.
package delay_line_mc_pkg;

  localparam int DEFAULT_WIDTH    = 24;
  localparam int DEFAULT_DEPTH    = 8;
  localparam int DEFAULT_CHANNELS = 4;
  localparam int SCAN_CHAINS      = 5;

  // A single channel still needs a 1-bit tag so the ports never collapse to zero width.
  function automatic int ch_width(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

  function automatic int dly_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/delay_line_mc_ring.sv
// One channel's ring of past samples with its write pointer and synchronous clear.
module delay_line_mc_ring
  import delay_line_mc_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  parameter  int DEPTH = DEFAULT_DEPTH,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             we,
  input  logic [WIDTH-1:0] wdata,
  input  logic [PTR_W-1:0] rd_ofs,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] ptr;

  // An offset of 0 (delay of DEPTH) reads the slot about to be overwritten; a cleared ring reads 0.
  assign rd_data = clear ? '0 : mem[ptr - rd_ofs];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      ptr <= '0;
    end else if (clear) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      if (we) begin
        mem[0] <= wdata;
        ptr    <= PTR_W'(1);
      end else begin
        ptr <= '0;
      end
    end else if (we) begin
      mem[ptr] <= wdata;
      ptr      <= ptr + 1'b1;
    end
  end

endmodule

// File: rtl/delay_line_mc.sv
// Multi-channel programmable sample delay with a single registered ready/valid output stage.
module delay_line_mc
  import delay_line_mc_pkg::*;
#(
  parameter  int WIDTH    = DEFAULT_WIDTH,
  parameter  int DEPTH    = DEFAULT_DEPTH,
  parameter  int CHANNELS = DEFAULT_CHANNELS,
  localparam int CH_W     = ch_width(CHANNELS),
  localparam int DLY_W    = dly_width(DEPTH),
  localparam int PTR_W    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] x,
  input  logic [CH_W-1:0]  x_ch,
  input  logic             x_valid,
  output logic             x_ready,
  input  logic [DLY_W-1:0] dly,
  input  logic             ch_clear,
  output logic [WIDTH-1:0] y,
  output logic [CH_W-1:0]  y_ch,
  output logic             y_valid,
  input  logic             y_ready,
  input  logic             scan_enable,
  input  logic             scan_in0,
  input  logic             scan_in1,
  input  logic             scan_in2,
  input  logic             scan_in3,
  input  logic             scan_in4,
  output logic             scan_out0,
  output logic             scan_out1,
  output logic             scan_out2,
  output logic             scan_out3,
  output logic             scan_out4
);

  logic             accept;
  logic [DLY_W-1:0] dly_c;
  logic [WIDTH-1:0] ring_rd [CHANNELS];
  logic [WIDTH-1:0] rd_sel;

  assign x_ready = ~y_valid | y_ready;
  assign accept  = x_valid & x_ready;
  assign dly_c   = (dly > DLY_W'(DEPTH)) ? DLY_W'(DEPTH) : dly;

  // Scan chain is stitched in by DFT insertion; functionally it is a gated pass-through.
  assign scan_out0 = scan_enable & scan_in0;
  assign scan_out1 = scan_enable & scan_in1;
  assign scan_out2 = scan_enable & scan_in2;
  assign scan_out3 = scan_enable & scan_in3;
  assign scan_out4 = scan_enable & scan_in4;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ring
    logic sel;
    assign sel = (x_ch == CH_W'(c));

    delay_line_mc_ring #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_ring (
      .clk     (clk),
      .reset   (reset),
      .clear   (ch_clear & sel),
      .we      (accept & sel),
      .wdata   (x),
      .rd_ofs  (dly_c[PTR_W-1:0]),
      .rd_data (ring_rd[c])
    );
  end

  always_comb begin
    rd_sel = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (x_ch == CH_W'(c)) rd_sel = ring_rd[c];
    end
  end

  // Output register: loads on accept, holds while stalled, drops valid once drained.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      y       <= '0;
      y_ch    <= '0;
      y_valid <= 1'b0;
    end else if (accept) begin
      y       <= (dly_c == '0) ? x : rd_sel;
      y_ch    <= x_ch;
      y_valid <= 1'b1;
    end else if (y_ready) begin
      y_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_delay_line_mc.sv
// Self-checking bench for delay_line_mc: directed scenarios plus random traffic against a history model.
module tb_delay_line_mc;

  localparam int WIDTH    = 24;
  localparam int DEPTH    = 8;
  localparam int CHANNELS = 4;

  logic             test_clk;
  logic             reset;
  logic [WIDTH-1:0] x;
  logic [1:0]       x_ch;
  logic             x_valid;
  logic             x_ready;
  logic [3:0]       dly;
  logic             ch_clear;
  logic [WIDTH-1:0] y;
  logic [1:0]       y_ch;
  logic             y_valid;
  logic             y_ready;
  logic             scan_enable;
  logic [4:0]       scan_in;
  logic [4:0]       scan_out;

  int n_total;
  int n_pass;

  // Model: newest-first history of each channel's accepted samples since reset/clear.
  logic [WIDTH-1:0] recent [CHANNELS][DEPTH];
  int               cnt    [CHANNELS];
  logic             m_valid;
  logic [WIDTH-1:0] m_y;
  logic [1:0]       m_ch;
  logic             last_accept;

  delay_line_mc #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .CHANNELS (CHANNELS)
  ) dut (
    .clk         (test_clk),
    .reset       (reset),
    .x           (x),
    .x_ch        (x_ch),
    .x_valid     (x_valid),
    .x_ready     (x_ready),
    .dly         (dly),
    .ch_clear    (ch_clear),
    .y           (y),
    .y_ch        (y_ch),
    .y_valid     (y_valid),
    .y_ready     (y_ready),
    .scan_enable (scan_enable),
    .scan_in0    (scan_in[0]),
    .scan_in1    (scan_in[1]),
    .scan_in2    (scan_in[2]),
    .scan_in3    (scan_in[3]),
    .scan_in4    (scan_in[4]),
    .scan_out0   (scan_out[0]),
    .scan_out1   (scan_out[1]),
    .scan_out2   (scan_out[2]),
    .scan_out3   (scan_out[3]),
    .scan_out4   (scan_out[4])
  );

  initial test_clk = 1'b0;
  always #5 test_clk = ~test_clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic modelReset();
    for (int c = 0; c < CHANNELS; c++) cnt[c] = 0;
    m_valid = 1'b0;
    m_y     = '0;
    m_ch    = '0;
  endtask

  // Runs one clock: predicts from pre-edge inputs, then checks the output register after the edge.
  task automatic tick();
    int c;
    int d;
    logic [WIDTH-1:0] exp_y;
    #1;
    checkOutput("x_ready", 32'(x_ready), 32'(!m_valid || y_ready));
    c = int'(x_ch);
    d = (int'(dly) > DEPTH) ? DEPTH : int'(dly);
    last_accept = x_valid && (!m_valid || y_ready);
    if (m_valid && y_ready) m_valid = 1'b0;
    if (ch_clear) cnt[c] = 0;
    if (last_accept) begin
      if (d == 0)          exp_y = x;
      else if (cnt[c] >= d) exp_y = recent[c][d-1];
      else                  exp_y = '0;
      for (int k = DEPTH - 1; k > 0; k--) recent[c][k] = recent[c][k-1];
      recent[c][0] = x;
      cnt[c]++;
      m_valid = 1'b1;
      m_y     = exp_y;
      m_ch    = x_ch;
    end
    @(posedge test_clk);
    #1;
    checkOutput("y_valid", 32'(y_valid), 32'(m_valid));
    if (m_valid) begin
      checkOutput("y", 32'(y), 32'(m_y));
      checkOutput("y_ch", 32'(y_ch), 32'(m_ch));
    end
    @(negedge test_clk);
  endtask

  task automatic applyStimulus(input logic v, input int ch, input logic [WIDTH-1:0] data,
                               input int d, input logic clr, input logic rdy);
    x_valid  = v;
    x_ch     = 2'(ch);
    x        = data;
    dly      = 4'(d);
    ch_clear = clr;
    y_ready  = rdy;
    tick();
  endtask

  initial begin
    int n [CHANNELS];
    int k;
    n_total     = 0;
    n_pass      = 0;
    last_accept = 1'b0;
    reset       = 1'b0;
    x           = '0;
    x_ch        = '0;
    x_valid     = 1'b0;
    dly         = '0;
    ch_clear    = 1'b0;
    y_ready     = 1'b1;
    scan_enable = 1'b0;
    scan_in     = '0;
    modelReset();

    repeat (2) @(negedge test_clk);
    checkOutput("reset_y", 32'(y), 32'd0);
    checkOutput("reset_y_ch", 32'(y_ch), 32'd0);
    checkOutput("reset_y_valid", 32'(y_valid), 32'd0);
    reset = 1'b1;
    @(negedge test_clk);
    checkOutput("x_ready_after_reset", 32'(x_ready), 32'd1);

    $display("[TB] full-depth delay on channel 0");
    for (int i = 1; i <= 20; i++) applyStimulus(1'b1, 0, WIDTH'(i), 8, 1'b0, 1'b1);

    $display("[TB] bypass and clamped delay");
    applyStimulus(1'b1, 0, 24'hABCDEF, 0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 0, WIDTH'(24'h100 + i), 9, 1'b0, 1'b1);
    applyStimulus(1'b0, 0, '0, 9, 1'b0, 1'b1);

    $display("[TB] interleaved channels with idle gaps");
    for (int c = 0; c < CHANNELS; c++) begin
      applyStimulus(1'b0, c, '0, 2, 1'b1, 1'b1);
      n[c] = 0;
    end
    for (int s = 0; s < 48; s++) begin
      int c;
      c = s % CHANNELS;
      if ($urandom_range(0, 2) == 0) applyStimulus(1'b0, c, '0, 2, 1'b0, 1'b1);
      applyStimulus(1'b1, c, WIDTH'(c * 256 + n[c]), 2, 1'b0, 1'b1);
      if (last_accept) n[c]++;
    end

    $display("[TB] output stall");
    k = 0;
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 0, WIDTH'(24'h300 + k), 2, 1'b0, !(i >= 5 && i < 10));
      if (last_accept) k++;
    end
    applyStimulus(1'b0, 2, '0, 3, 1'b1, 1'b0);
    applyStimulus(1'b0, 2, '0, 3, 1'b0, 1'b1);

    $display("[TB] channel clear with concurrent sample");
    applyStimulus(1'b0, 0, '0, 3, 1'b1, 1'b1);
    applyStimulus(1'b0, 1, '0, 3, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 1, WIDTH'(24'h1000 + i), 3, 1'b0, 1'b1);
      applyStimulus(1'b1, 0, WIDTH'(24'h2000 + i), 3, 1'b0, 1'b1);
    end
    applyStimulus(1'b1, 1, 24'h000055, 3, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 0, WIDTH'(24'h2100 + i), 3, 1'b0, 1'b1);
      applyStimulus(1'b1, 1, WIDTH'(24'h1100 + i), 3, 1'b0, 1'b1);
    end

    $display("[TB] random traffic");
    for (int i = 0; i < 600; i++) begin
      applyStimulus($urandom_range(0, 3) != 0, int'($urandom_range(0, CHANNELS - 1)),
                    WIDTH'($urandom), int'($urandom_range(0, 15)),
                    $urandom_range(0, 31) == 0, $urandom_range(0, 3) != 0);
    end

    $display("[TB] asynchronous reset mid-stream");
    applyStimulus(1'b1, 3, 24'h5A5A5A, 0, 1'b0, 1'b1);
    x_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    checkOutput("async_reset_y_valid", 32'(y_valid), 32'd0);
    checkOutput("async_reset_y", 32'(y), 32'd0);
    modelReset();
    @(negedge test_clk);
    reset = 1'b1;
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b1, i % CHANNELS, WIDTH'(24'h700 + i), 3, 1'b0, 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
